// File: rtl/rv32_load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module : rv32_lsu_req_if / rv32_lsu_mem_if
// Brief  : Execute-side request bundle and word-wide memory-port bundle.
// Rev    : 1.0
// ============================================================================

interface rv32_lsu_req_if;
    logic        lsu_valid;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic        lsu_fault;
    logic [31:0] lsu_rdata;

    modport master (
        output lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  lsu_busy, lsu_done, lsu_fault, lsu_rdata
    );
    modport slave (
        input  lsu_valid, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output lsu_busy, lsu_done, lsu_fault, lsu_rdata
    );
endinterface

interface rv32_lsu_mem_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read_req;
    logic              mem_write_req;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wait;
    logic              mem_rdata_valid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_read_req, mem_write_req, mem_wdata,
        input  mem_wait, mem_rdata_valid, mem_rdata
    );
    modport slave (
        input  mem_addr, mem_read_req, mem_write_req, mem_wdata,
        output mem_wait, mem_rdata_valid, mem_rdata
    );
endinterface

`default_nettype wire

// File: rtl/rv32_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : rv32_load_store_unit
// Brief  : RV32I load/store unit with sub-word read-modify-write over a
//          word-only memory port; faults misaligned/illegal accesses.
// Rev    : 1.0
// ============================================================================

module rv32_load_store_unit #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 32
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    rv32_lsu_req_if.slave    lsu,
    rv32_lsu_mem_if.master   mem
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_we;
    logic [2:0]        r_funct3;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic              r_fault;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [31:0]       r_rdata;

    logic              w_illegal;
    logic              w_misaligned;
    logic              w_fault;
    logic [DATA_W-1:0] w_shift;
    logic [31:0]       w_load;
    logic [DATA_W-1:0] w_merged;

    // Only halfword and word sizes carry alignment constraints.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (lsu.lsu_we) begin
            w_illegal = (lsu.lsu_funct3 >= 3'd3);
        end else begin
            w_illegal = (lsu.lsu_funct3 == 3'd3) || (lsu.lsu_funct3 == 3'd6) ||
                        (lsu.lsu_funct3 == 3'd7);
        end
        if ((lsu.lsu_funct3[1:0] == 2'd1) && lsu.lsu_addr[0]) begin
            w_misaligned = 1'b1;
        end
        if ((lsu.lsu_funct3[1:0] == 2'd2) && (lsu.lsu_addr[1:0] != 2'b00)) begin
            w_misaligned = 1'b1;
        end
        w_fault = w_illegal || w_misaligned;
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (lsu.lsu_valid) begin
                    if (w_fault) begin
                        w_next = ST_DONE;
                    end else if (lsu.lsu_we && (lsu.lsu_funct3 == 3'd2)) begin
                        w_next = ST_WR_REQ;
                    end else begin
                        w_next = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (!mem.mem_wait) begin
                    w_next = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (mem.mem_rdata_valid) begin
                    w_next = r_we ? ST_WR_REQ : ST_DONE;
                end
            end
            ST_WR_REQ: begin
                if (!mem.mem_wait) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Halfword lanes are always even-aligned here, so a byte-granular shift covers both sizes.
    always_comb begin
        w_shift = mem.mem_rdata >> {r_addr[1:0], 3'b000};
        case (r_funct3)
            3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd1:    w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd4:    w_load = {24'd0, w_shift[7:0]};
            3'd5:    w_load = {16'd0, w_shift[15:0]};
            default: w_load = mem.mem_rdata[31:0];
        endcase
    end

    always_comb begin
        w_merged = mem.mem_rdata;
        if (r_funct3[1:0] == 2'd0) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_fault     <= 1'b0;
            r_mem_wdata <= '0;
            r_rdata     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (lsu.lsu_valid) begin
                        r_we        <= lsu.lsu_we;
                        r_funct3    <= lsu.lsu_funct3;
                        r_addr      <= lsu.lsu_addr;
                        r_wdata     <= lsu.lsu_wdata;
                        r_fault     <= w_fault;
                        r_mem_wdata <= lsu.lsu_wdata;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem.mem_rdata_valid) begin
                        if (r_we) begin
                            r_mem_wdata <= w_merged;
                        end else begin
                            r_rdata <= w_load;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Address bits above the memory word range are captured but never leave the unit.
    generate
        if (ADDR_W < 30) begin : g_addr_hi_sink
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = &{1'b0, r_addr[31:ADDR_W+2]};
        end
    endgenerate

    assign lsu.lsu_busy      = (r_state != ST_IDLE);
    assign lsu.lsu_done      = (r_state == ST_DONE);
    assign lsu.lsu_fault     = (r_state == ST_DONE) && r_fault;
    assign lsu.lsu_rdata     = r_rdata;

    assign mem.mem_addr      = r_addr[ADDR_W+1:2];
    assign mem.mem_read_req  = (r_state == ST_RD_REQ);
    assign mem.mem_write_req = (r_state == ST_WR_REQ);
    assign mem.mem_wdata     = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rv32_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_rv32_load_store_unit
// Brief  : Directed self-checking bench with a word-memory responder model.
// Rev    : 1.0
// ============================================================================

module tb_rv32_load_store_unit;

    logic iCLK = 1'b0;
    logic iRST_n = 1'b0;
    always #5 iCLK = ~iCLK;

    rv32_lsu_req_if lsu ();
    rv32_lsu_mem_if #(.ADDR_W(28), .DATA_W(32)) mem ();

    rv32_load_store_unit #(.ADDR_W(28), .DATA_W(32)) dut (
        .iCLK   (iCLK),
        .iRST_n (iRST_n),
        .lsu    (lsu),
        .mem    (mem)
    );

    int n_checks = 0;
    int n_fail = 0;

    int n_rd = 0;
    int n_wr = 0;
    int req_cycles = 0;
    int both_cnt = 0;
    int cfg_wait = 0;
    int cfg_lat = 0;
    int wait_left = 0;
    int rd_cnt = 0;
    bit rd_pending = 1'b0;
    logic [7:0]  rd_idx = 8'd0;
    logic [27:0] last_waddr = 28'd0;
    logic [31:0] mem_arr [256];

    // Memory responder: decides mem_wait for the coming edge and returns read data after cfg_lat extra cycles.
    initial begin
        mem.mem_wait = 1'b0;
        mem.mem_rdata_valid = 1'b0;
        mem.mem_rdata = 32'd0;
        forever begin
            @(negedge iCLK);
            mem.mem_rdata_valid = 1'b0;
            if (rd_pending) begin
                if (rd_cnt == 0) begin
                    mem.mem_rdata_valid = 1'b1;
                    mem.mem_rdata = mem_arr[rd_idx];
                    rd_pending = 1'b0;
                end else begin
                    rd_cnt--;
                end
            end
            if (mem.mem_read_req && mem.mem_write_req) both_cnt++;
            if (mem.mem_read_req || mem.mem_write_req) begin
                req_cycles++;
                if (wait_left > 0) begin
                    mem.mem_wait = 1'b1;
                    wait_left--;
                end else begin
                    mem.mem_wait = 1'b0;
                    wait_left = cfg_wait;
                    if (mem.mem_read_req) begin
                        n_rd++;
                        rd_pending = 1'b1;
                        rd_cnt = cfg_lat;
                        rd_idx = mem.mem_addr[7:0];
                    end else begin
                        n_wr++;
                        mem_arr[mem.mem_addr[7:0]] = mem.mem_wdata;
                        last_waddr = mem.mem_addr;
                    end
                end
            end else begin
                mem.mem_wait = 1'b0;
            end
        end
    end

    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int cyc, output logic flt);
        @(negedge iCLK);
        lsu.lsu_valid = 1'b1;
        lsu.lsu_we = we;
        lsu.lsu_funct3 = f3;
        lsu.lsu_addr = a;
        lsu.lsu_wdata = wd;
        @(negedge iCLK);
        lsu.lsu_valid = 1'b0;
        cyc = 1;
        while (lsu.lsu_done !== 1'b1 && cyc < 200) begin
            @(negedge iCLK);
            cyc++;
        end
        flt = lsu.lsu_fault;
        if (cyc >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL op_timeout: no lsu_done after %0d cycles, required completion", cyc);
        end
    endtask

    task automatic test_reset;
        lsu.lsu_valid = 1'b0;
        lsu.lsu_we = 1'b0;
        lsu.lsu_funct3 = 3'd0;
        lsu.lsu_addr = 32'd0;
        lsu.lsu_wdata = 32'd0;
        repeat (3) @(posedge iCLK);
        #1;
        n_checks++; if (lsu.lsu_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", lsu.lsu_busy); end
        n_checks++; if (lsu.lsu_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", lsu.lsu_done); end
        n_checks++; if (lsu.lsu_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", lsu.lsu_rdata); end
        n_checks++; if ({mem.mem_read_req, mem.mem_write_req} !== 2'b00) begin n_fail++; $display("FAIL rst_reqs: got %b expected 00", {mem.mem_read_req, mem.mem_write_req}); end
        n_checks++; if (mem.mem_addr !== 28'd0 || mem.mem_wdata !== 32'd0) begin n_fail++; $display("FAIL rst_mem_out: got addr %h wdata %h expected 0/0", mem.mem_addr, mem.mem_wdata); end
        @(negedge iCLK);
        iRST_n = 1'b1;
    endtask

    task automatic test_store_word;
        int cyc; logic flt; int rd0, wr0;
        rd0 = n_rd; wr0 = n_wr;
        do_op(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, cyc, flt);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", cyc); end
        n_checks++; if (flt !== 1'b0) begin n_fail++; $display("FAIL sw_fault: got %b expected 0", flt); end
        n_checks++; if (n_wr - wr0 !== 1 || n_rd - rd0 !== 0) begin n_fail++; $display("FAIL sw_req_count: got wr %0d rd %0d expected 1/0", n_wr - wr0, n_rd - rd0); end
        n_checks++; if (last_waddr !== 28'h40) begin n_fail++; $display("FAIL sw_addr: got %h expected 40", last_waddr); end
        n_checks++; if (mem_arr[8'h40] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sw_data: got %h expected deadbeef", mem_arr[8'h40]); end
    endtask

    task automatic test_loads;
        int cyc; logic flt;
        mem_arr[8'h40] = 32'h80FF_1234;
        do_op(1'b0, 3'd0, 32'h0000_0103, 32'd0, cyc, flt);
        n_checks++; if (cyc !== 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", cyc); end
        n_checks++; if (lsu.lsu_rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_sext: got %h expected ffffff80", lsu.lsu_rdata); end
        do_op(1'b0, 3'd4, 32'h0000_0103, 32'd0, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_zext: got %h expected 00000080", lsu.lsu_rdata); end
        do_op(1'b0, 3'd1, 32'h0000_0102, 32'd0, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'hFFFF_80FF) begin n_fail++; $display("FAIL lh_sext: got %h expected ffff80ff", lsu.lsu_rdata); end
        do_op(1'b0, 3'd5, 32'h0000_0102, 32'd0, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'h0000_80FF) begin n_fail++; $display("FAIL lhu_zext: got %h expected 000080ff", lsu.lsu_rdata); end
        do_op(1'b0, 3'd2, 32'h0000_0100, 32'd0, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'h80FF_1234) begin n_fail++; $display("FAIL lw_data: got %h expected 80ff1234", lsu.lsu_rdata); end
        do_op(1'b0, 3'd0, 32'h0000_0100, 32'd0, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'h0000_0034 || flt !== 1'b0) begin n_fail++; $display("FAIL lb_lane0: got %h fault %b expected 00000034/0", lsu.lsu_rdata, flt); end
    endtask

    task automatic test_store_byte;
        int cyc; logic flt; int rd0, wr0;
        mem_arr[8'h40] = 32'h1122_3344;
        rd0 = n_rd; wr0 = n_wr;
        do_op(1'b1, 3'd0, 32'h0000_0101, 32'h0000_00AB, cyc, flt);
        n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL sb_latency: got %0d expected 4", cyc); end
        n_checks++; if (n_rd - rd0 !== 1 || n_wr - wr0 !== 1) begin n_fail++; $display("FAIL sb_req_count: got rd %0d wr %0d expected 1/1", n_rd - rd0, n_wr - wr0); end
        n_checks++; if (mem_arr[8'h40] !== 32'h1122_AB44) begin n_fail++; $display("FAIL sb_merge: got %h expected 1122ab44", mem_arr[8'h40]); end
        n_checks++; if (last_waddr !== 28'h40) begin n_fail++; $display("FAIL sb_addr: got %h expected 40", last_waddr); end
        n_checks++; if (lsu.lsu_rdata !== 32'h0000_0034) begin n_fail++; $display("FAIL sb_rdata_kept: got %h expected 00000034", lsu.lsu_rdata); end
    endtask

    task automatic test_faults;
        int cyc; logic flt; int rq0;
        rq0 = req_cycles;
        do_op(1'b0, 3'd2, 32'h0000_0102, 32'd0, cyc, flt);
        n_checks++; if (flt !== 1'b1 || cyc !== 1) begin n_fail++; $display("FAIL lw_misalign: got fault %b cyc %0d expected 1/1", flt, cyc); end
        do_op(1'b1, 3'd1, 32'h0000_0103, 32'h0000_5566, cyc, flt);
        n_checks++; if (flt !== 1'b1 || cyc !== 1) begin n_fail++; $display("FAIL sh_misalign: got fault %b cyc %0d expected 1/1", flt, cyc); end
        do_op(1'b0, 3'd3, 32'h0000_0100, 32'd0, cyc, flt);
        n_checks++; if (flt !== 1'b1) begin n_fail++; $display("FAIL load_illegal: got fault %b expected 1", flt); end
        do_op(1'b1, 3'd4, 32'h0000_0100, 32'd0, cyc, flt);
        n_checks++; if (flt !== 1'b1) begin n_fail++; $display("FAIL store_illegal: got fault %b expected 1", flt); end
        do_op(1'b0, 3'd5, 32'h0000_0101, 32'd0, cyc, flt);
        n_checks++; if (flt !== 1'b1) begin n_fail++; $display("FAIL lhu_misalign: got fault %b expected 1", flt); end
        @(negedge iCLK);
        n_checks++; if (lsu.lsu_fault !== 1'b0 || lsu.lsu_done !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got fault %b done %b expected 0/0", lsu.lsu_fault, lsu.lsu_done); end
        n_checks++; if (req_cycles - rq0 !== 0) begin n_fail++; $display("FAIL fault_no_mem: got %0d request cycles expected 0", req_cycles - rq0); end
        n_checks++; if (lsu.lsu_rdata !== 32'h0000_0034) begin n_fail++; $display("FAIL fault_rdata_kept: got %h expected 00000034", lsu.lsu_rdata); end
    endtask

    task automatic test_back_to_back;
        int cyc; logic flt;
        do_op(1'b1, 3'd1, 32'h0000_0102, 32'hFFFF_5566, cyc, flt);
        n_checks++; if (mem_arr[8'h40] !== 32'h5566_AB44 || cyc !== 4) begin n_fail++; $display("FAIL sh_merge: got %h cyc %0d expected 5566ab44/4", mem_arr[8'h40], cyc); end
        do_op(1'b0, 3'd5, 32'h0000_0102, 32'd0, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'h0000_5566) begin n_fail++; $display("FAIL b2b_lhu: got %h expected 00005566", lsu.lsu_rdata); end
        do_op(1'b1, 3'd2, 32'h0000_0104, 32'h0000_0000, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'h0000_5566) begin n_fail++; $display("FAIL b2b_sw_rdata_kept: got %h expected 00005566", lsu.lsu_rdata); end
        do_op(1'b0, 3'd0, 32'h0000_0101, 32'd0, cyc, flt);
        n_checks++; if (lsu.lsu_rdata !== 32'hFFFF_FFAB) begin n_fail++; $display("FAIL b2b_lb: got %h expected ffffffab", lsu.lsu_rdata); end
    endtask

    task automatic test_mem_wait;
        int cyc; int rq; int bad; int wr0;
        mem_arr[8'h41] = 32'hCAFE_F00D;
        cfg_wait = 3; wait_left = 3; cfg_lat = 2;
        wr0 = n_wr; rq = 0; bad = 0;
        @(negedge iCLK);
        lsu.lsu_valid = 1'b1; lsu.lsu_we = 1'b0; lsu.lsu_funct3 = 3'd2;
        lsu.lsu_addr = 32'h0000_0104; lsu.lsu_wdata = 32'd0;
        @(negedge iCLK);
        lsu.lsu_valid = 1'b0;
        cyc = 1;
        while (lsu.lsu_done !== 1'b1 && cyc < 200) begin
            if (cyc == 2 || cyc == 5) begin
                lsu.lsu_valid = 1'b1; lsu.lsu_we = 1'b1; lsu.lsu_funct3 = 3'd2;
                lsu.lsu_addr = 32'h0000_0200; lsu.lsu_wdata = 32'h1234_5678;
            end else begin
                lsu.lsu_valid = 1'b0;
            end
            if (mem.mem_read_req) begin
                rq++;
                if (mem.mem_addr !== 28'h41 || mem.mem_write_req !== 1'b0) bad++;
            end
            @(negedge iCLK);
            cyc++;
        end
        lsu.lsu_valid = 1'b0;
        n_checks++; if (cyc !== 8) begin n_fail++; $display("FAIL wait_latency: got %0d expected 8", cyc); end
        n_checks++; if (rq !== 4) begin n_fail++; $display("FAIL wait_req_cycles: got %0d expected 4", rq); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL wait_req_stable: got %0d unstable cycles expected 0", bad); end
        n_checks++; if (lsu.lsu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wait_rdata: got %h expected cafef00d", lsu.lsu_rdata); end
        repeat (3) @(negedge iCLK);
        n_checks++; if (lsu.lsu_busy !== 1'b0 || n_wr - wr0 !== 0) begin n_fail++; $display("FAIL busy_valid_ignored: got busy %b writes %0d expected 0/0", lsu.lsu_busy, n_wr - wr0); end
        cfg_wait = 0; wait_left = 0; cfg_lat = 0;
    endtask

    task automatic test_reset_mid_op;
        int cyc; logic flt; int bad;
        cfg_lat = 4;
        bad = 0;
        @(negedge iCLK);
        lsu.lsu_valid = 1'b1; lsu.lsu_we = 1'b0; lsu.lsu_funct3 = 3'd2;
        lsu.lsu_addr = 32'h0000_0104; lsu.lsu_wdata = 32'd0;
        @(negedge iCLK);
        lsu.lsu_valid = 1'b0;
        @(negedge iCLK);
        n_checks++; if (lsu.lsu_busy !== 1'b1 || mem.mem_read_req !== 1'b0) begin n_fail++; $display("FAIL rd_wait_state: got busy %b rreq %b expected 1/0", lsu.lsu_busy, mem.mem_read_req); end
        #2 iRST_n = 1'b0;
        #1;
        n_checks++; if (lsu.lsu_busy !== 1'b0 || lsu.lsu_done !== 1'b0 || lsu.lsu_fault !== 1'b0) begin n_fail++; $display("FAIL midrst_status: got busy %b done %b fault %b expected 000", lsu.lsu_busy, lsu.lsu_done, lsu.lsu_fault); end
        n_checks++; if (lsu.lsu_rdata !== 32'd0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", lsu.lsu_rdata); end
        n_checks++; if (mem.mem_addr !== 28'd0 || mem.mem_wdata !== 32'd0 || mem.mem_read_req !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_out: got addr %h wdata %h rreq %b expected 0", mem.mem_addr, mem.mem_wdata, mem.mem_read_req); end
        @(negedge iCLK);
        #2 iRST_n = 1'b1;
        repeat (6) begin
            @(negedge iCLK);
            if (lsu.lsu_done !== 1'b0 || lsu.lsu_busy !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL late_strobe_ignored: got %0d active cycles expected 0", bad); end
        n_checks++; if (lsu.lsu_rdata !== 32'd0) begin n_fail++; $display("FAIL late_strobe_rdata: got %h expected 0", lsu.lsu_rdata); end
        cfg_lat = 0;
        do_op(1'b0, 3'd2, 32'h0000_0104, 32'd0, cyc, flt);
        n_checks++; if (cyc !== 3 || flt !== 1'b0) begin n_fail++; $display("FAIL post_rst_lw_timing: got cyc %0d fault %b expected 3/0", cyc, flt); end
        n_checks++; if (lsu.lsu_rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL post_rst_lw_data: got %h expected cafef00d", lsu.lsu_rdata); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'd0;
        test_reset();
        test_store_word();
        test_loads();
        test_store_byte();
        test_faults();
        test_back_to_back();
        test_mem_wait();
        test_reset_mid_op();
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL req_exclusive: got %0d cycles with both requests expected 0", both_cnt); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
